// File: rtl/dmem_responder.sv
// dmem_responder: tagged load/store memory responder returning each tag after a fixed latency
module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int LATENCY = 4,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        proc2mem_command,
  input  logic [ADDR_W-1:0] proc2mem_addr,
  input  logic [63:0]       proc2mem_data,
  output logic [3:0]        mem2proc_response,
  output logic [63:0]       mem2proc_data,
  output logic [3:0]        mem2proc_tag
);
  localparam int DEPTH = 2 ** (ADDR_W - 3);
  localparam int RW = REFRESH_PERIOD > 1 ? $clog2(REFRESH_PERIOD) : 1;
  logic [63:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [14:0] busy, set_mask, clr_mask;
  logic [RW-1:0] rcnt;
  logic [3:0] free_tag;
  logic [3:0] p_tag [LATENCY];
  logic [63:0] p_data [LATENCY];
  logic [ADDR_W-4:0] idx;
  logic [63:0] rdata;
  logic is_cmd, is_store, refresh, accept;
  logic unused_lsbs;
  assign unused_lsbs = ^proc2mem_addr[2:0];
  assign idx = proc2mem_addr[ADDR_W-1:3];
  always_comb begin
    free_tag = '0;
    for (int i = 15; i >= 1; i--)
      if (!busy[i-1]) free_tag = 4'(i);
  end
  assign is_cmd = proc2mem_command == 2'd1 || proc2mem_command == 2'd2;
  assign is_store = proc2mem_command == 2'd2;
  assign refresh = rcnt == RW'(REFRESH_PERIOD - 1);
  assign accept = !reset && is_cmd && free_tag != 4'd0 && !refresh;
  assign mem2proc_response = accept ? free_tag : 4'd0;
  assign rdata = is_store ? proc2mem_data : (written[idx] ? mem[idx] : 64'd0);
  assign set_mask = accept ? 15'd1 << (free_tag - 4'd1) : 15'd0;
  assign clr_mask = mem2proc_tag != 4'd0 ? 15'd1 << (mem2proc_tag - 4'd1) : 15'd0;
  assign mem2proc_tag = p_tag[LATENCY-1];
  assign mem2proc_data = p_data[LATENCY-1];
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      rcnt <= '0;
      written <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_tag[i] <= '0;
        p_data[i] <= '0;
      end
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      rcnt <= refresh ? '0 : rcnt + RW'(1);
      if (accept && is_store) written[idx] <= 1'b1;
      p_tag[0] <= mem2proc_response;
      p_data[0] <= accept ? rdata : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        p_tag[i] <= p_tag[i-1];
        p_data[i] <= p_data[i-1];
      end
    end
  end
  always_ff @(posedge clock)
    if (accept && is_store) mem[idx] <= proc2mem_data;
endmodule
